javk_biu: RTL and testbench

Bus interface unit for the JAVK CPU. Sits between the core's execute/fetch logic and the external 8-bit `databus` / 16-bit `addrbus`, turning one core request (8-bit or 16-bit, read or write) into one or two byte-wide bus beats. It sequences little-endian word accesses, inserts a fixed number of wait states per beat, and owns the tristate control of `databus`.

---
 rtl/javk_biu.sv | 117 +++++++++++
 tb/tb_javk_biu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/javk_biu.sv
// JAVK bus interface unit.
// Turns one core request (byte or little-endian word, read or write) into one or two
// byte-wide beats on the external bus. Each beat is stretched by WAIT_STATES cycles.
// The unit drives databus only during write beats.
module javk_biu #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wide,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic [15:0] addrbus,
    output logic        rw,
    inout  wire  [7:0]  databus
);

    typedef enum logic [1:0] {
        StIdle,
        StBeat0,
        StBeat1
    } state_e;

    localparam logic [3:0] WaitLoad = 4'(WAIT_STATES);

    state_e      state_q;
    logic [3:0]  wcnt_q;
    logic [15:0] addr_q;
    logic        wide_q;
    logic        wr_q;
    logic [7:0]  whi_q;    // high write byte, held for the second beat
    logic [7:0]  wbyte_q;  // byte currently presented on databus

    // Busy is a pure decode of the state register.
    assign busy = (state_q != StIdle);

    // Drive the bus only during a write beat; rw is registered, so the enable is glitch-free.
    assign databus = rw ? wbyte_q : 8'bz;

    // Access sequencer: request capture, beat timing, read capture and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            wcnt_q  <= 4'd0;
            addr_q  <= 16'd0;
            wide_q  <= 1'b0;
            wr_q    <= 1'b0;
            whi_q   <= 8'd0;
            wbyte_q <= 8'd0;
            addrbus <= 16'd0;
            rw      <= 1'b0;
            rdata   <= 16'd0;
            ready   <= 1'b0;
        end else begin
            ready <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req) begin
                        addr_q  <= addr;
                        wr_q    <= wr;
                        wide_q  <= wide;
                        whi_q   <= wdata[15:8];
                        addrbus <= addr;
                        rw      <= wr;
                        wbyte_q <= wdata[7:0];
                        wcnt_q  <= WaitLoad;
                        state_q <= StBeat0;
                    end
                end
                StBeat0: begin
                    if (wcnt_q != 4'd0) begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end else begin
                        if (!wr_q) begin
                            rdata[7:0] <= databus;
                        end
                        if (wide_q) begin
                            // 16-bit wrap: a word at FFFF takes its high byte from 0000.
                            addrbus <= addr_q + 16'd1;
                            wbyte_q <= whi_q;
                            wcnt_q  <= WaitLoad;
                            state_q <= StBeat1;
                        end else begin
                            if (!wr_q) begin
                                rdata[15:8] <= 8'd0;
                            end
                            rw      <= 1'b0;
                            ready   <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                end
                StBeat1: begin
                    if (wcnt_q != 4'd0) begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end else begin
                        if (!wr_q) begin
                            rdata[15:8] <= databus;
                        end
                        rw      <= 1'b0;
                        ready   <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_javk_biu.sv
// Directed bench for javk_biu: three instances (0, 2 and 3 wait states) share the core-side
// inputs and a byte memory model that answers whenever a unit is not driving its bus.
module tb_javk_biu;

    logic        clk;
    logic        rst;
    logic        wide;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        req0, req2, req3;

    logic [15:0] rdata0, rdata2, rdata3;
    logic        ready0, ready2, ready3;
    logic        busy0, busy2, busy3;
    logic [15:0] addrbus0, addrbus2, addrbus3;
    logic        rw0, rw2, rw3;
    wire  [7:0]  db0, db2, db3;

    logic [7:0]  mem [0:65535];

    int n_checks;
    int n_fail;

    // External memory answers only while the unit is not driving.
    assign db0 = rw0 ? 8'bz : mem[addrbus0];
    assign db2 = rw2 ? 8'bz : mem[addrbus2];
    assign db3 = rw3 ? 8'bz : mem[addrbus3];

    javk_biu #(.WAIT_STATES(0)) u_w0 (
        .clk(clk), .rst(rst), .req(req0), .wide(wide), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata0), .ready(ready0), .busy(busy0), .addrbus(addrbus0), .rw(rw0),
        .databus(db0)
    );

    javk_biu #(.WAIT_STATES(2)) u_w2 (
        .clk(clk), .rst(rst), .req(req2), .wide(wide), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata2), .ready(ready2), .busy(busy2), .addrbus(addrbus2), .rw(rw2),
        .databus(db2)
    );

    javk_biu #(.WAIT_STATES(3)) u_w3 (
        .clk(clk), .rst(rst), .req(req3), .wide(wide), .wr(wr), .addr(addr), .wdata(wdata),
        .rdata(rdata3), .ready(ready3), .busy(busy3), .addrbus(addrbus3), .rw(rw3),
        .databus(db3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic seen;
        n_checks = 0;
        n_fail   = 0;
        mem[16'h0000] = 8'h3C;
        mem[16'h1234] = 8'hA5;
        mem[16'h0100] = 8'h34;
        mem[16'h0101] = 8'h12;
        mem[16'h4000] = 8'h99;

        rst = 1'b1; req0 = 1'b0; req2 = 1'b0; req3 = 1'b0;
        wide = 1'b0; wr = 1'b0; addr = 16'h0; wdata = 16'h0;
        tick();
        tick();
        rst = 1'b0;

        // Reset values and idle behaviour
        check_eq("rst_addrbus", addrbus0, 16'h0000);
        check_eq("rst_rdata", rdata0, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            check_eq("idle_rw", {15'd0, rw0}, 16'd0);
            check_eq("idle_busy", {15'd0, busy0}, 16'd0);
            check_eq("idle_ready", {15'd0, ready0}, 16'd0);
            check_eq("idle_addrbus", addrbus0, 16'h0000);
            check_eq("idle_bus_free", {8'd0, db0}, 16'h003C);
            tick();
        end

        // Narrow read, W=0
        addr = 16'h1234; wr = 1'b0; wide = 1'b0; req0 = 1'b1;
        tick();
        req0 = 1'b0;
        check_eq("nr_addrbus", addrbus0, 16'h1234);
        check_eq("nr_rw", {15'd0, rw0}, 16'd0);
        check_eq("nr_busy", {15'd0, busy0}, 16'd1);
        check_eq("nr_ready_early", {15'd0, ready0}, 16'd0);
        tick();
        check_eq("nr_ready", {15'd0, ready0}, 16'd1);
        check_eq("nr_rdata", rdata0, 16'h00A5);
        check_eq("nr_busy_done", {15'd0, busy0}, 16'd0);
        tick();
        check_eq("nr_ready_pulse", {15'd0, ready0}, 16'd0);
        check_eq("nr_rdata_hold", rdata0, 16'h00A5);

        // Wide write at FFFF, W=2
        addr = 16'hFFFF; wdata = 16'hBEEF; wr = 1'b1; wide = 1'b1; req2 = 1'b1;
        tick();
        req2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("ww_b0_addr", addrbus2, 16'hFFFF);
            check_eq("ww_b0_rw", {15'd0, rw2}, 16'd1);
            check_eq("ww_b0_data", {8'd0, db2}, 16'h00EF);
            check_eq("ww_b0_ready", {15'd0, ready2}, 16'd0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            check_eq("ww_b1_addr", addrbus2, 16'h0000);
            check_eq("ww_b1_rw", {15'd0, rw2}, 16'd1);
            check_eq("ww_b1_data", {8'd0, db2}, 16'h00BE);
            check_eq("ww_b1_ready", {15'd0, ready2}, 16'd0);
            tick();
        end
        check_eq("ww_ready", {15'd0, ready2}, 16'd1);
        check_eq("ww_rw_off", {15'd0, rw2}, 16'd0);
        check_eq("ww_busy", {15'd0, busy2}, 16'd0);
        check_eq("ww_rdata_kept", rdata2, 16'h0000);

        // Wide read, W=0
        addr = 16'h0100; wr = 1'b0; wide = 1'b1; req0 = 1'b1;
        tick();
        req0 = 1'b0;
        check_eq("wr_b0_addr", addrbus0, 16'h0100);
        check_eq("wr_b0_ready", {15'd0, ready0}, 16'd0);
        tick();
        check_eq("wr_b1_addr", addrbus0, 16'h0101);
        check_eq("wr_b1_busy", {15'd0, busy0}, 16'd1);
        check_eq("wr_b1_ready", {15'd0, ready0}, 16'd0);
        tick();
        check_eq("wr_ready", {15'd0, ready0}, 16'd1);
        check_eq("wr_rdata", rdata0, 16'h1234);

        // Back-to-back narrow read then narrow write, W=0, req held high
        addr = 16'h0100; wr = 1'b0; wide = 1'b0; req0 = 1'b1;
        tick();
        addr = 16'hDEAD; wr = 1'b1; wide = 1'b1; wdata = 16'hFFFF;
        tick();
        check_eq("bb_rd_ready", {15'd0, ready0}, 16'd1);
        check_eq("bb_rd_rdata", rdata0, 16'h0034);
        check_eq("bb_rd_addr", addrbus0, 16'h0100);
        check_eq("bb_idle", {15'd0, busy0}, 16'd0);
        addr = 16'h2000; wr = 1'b1; wide = 1'b0; wdata = 16'h0055;
        tick();
        req0 = 1'b0;
        check_eq("bb_wr_busy", {15'd0, busy0}, 16'd1);
        check_eq("bb_wr_addr", addrbus0, 16'h2000);
        check_eq("bb_wr_rw", {15'd0, rw0}, 16'd1);
        check_eq("bb_wr_data", {8'd0, db0}, 16'h0055);
        tick();
        check_eq("bb_wr_ready", {15'd0, ready0}, 16'd1);
        check_eq("bb_wr_rw_off", {15'd0, rw0}, 16'd0);
        check_eq("bb_wr_rdata", rdata0, 16'h0034);
        tick();
        check_eq("bb_end_ready", {15'd0, ready0}, 16'd0);
        check_eq("bb_end_busy", {15'd0, busy0}, 16'd0);

        // Reset in cycle 2 of a W=3 wide write
        addr = 16'h4000; wdata = 16'h1122; wr = 1'b1; wide = 1'b1; req3 = 1'b1;
        tick();
        req3 = 1'b0;
        check_eq("rm_rw", {15'd0, rw3}, 16'd1);
        check_eq("rm_busy", {15'd0, busy3}, 16'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rm_busy_after", {15'd0, busy3}, 16'd0);
        check_eq("rm_rw_after", {15'd0, rw3}, 16'd0);
        check_eq("rm_ready_after", {15'd0, ready3}, 16'd0);
        check_eq("rm_bus_free", {8'd0, db3}, 16'h003C);
        check_eq("rm_rdata", rdata3, 16'h0000);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (ready3) seen = 1'b1;
            tick();
        end
        check_eq("rm_no_ready", {15'd0, seen}, 16'd0);

        // New narrow read accepted after reset, W=3
        addr = 16'h1234; wr = 1'b0; wide = 1'b0; req3 = 1'b1;
        tick();
        req3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("rm_new_wait", {15'd0, ready3}, 16'd0);
            tick();
        end
        check_eq("rm_new_ready", {15'd0, ready3}, 16'd1);
        check_eq("rm_new_rdata", rdata3, 16'h00A5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
